aes_txn_sequencer: RTL

AES_TXN_SEQUENCER -- requirements
Module: aes_txn_sequencer

---
 rtl/aes_txn_sequencer_if.sv | 49 ++++
 rtl/aes_txn_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_txn_sequencer_if.sv
// rtl/aes_txn_sequencer_if.sv - request/response, key-core and cipher-core signal bundle
interface aes_txn_sequencer_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 256,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [KEY_W-1:0]  req_key;
    logic [1:0]        req_mode;
    logic [DATA_W-1:0] req_data;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [TAG_W-1:0]  rsp_tag;
    logic [1:0]        rsp_err;

    logic [KEY_W-1:0]  key_i_key;
    logic [1:0]        key_i_key_mode;
    logic              key_i_start;
    logic              key_o_key_ready;

    logic [DATA_W-1:0] cph_i_data;
    logic              cph_i_data_valid;
    logic              cph_i_ende;
    logic              cph_i_enable;
    logic              cph_o_ready;
    logic              cph_o_data_valid;
    logic [DATA_W-1:0] cph_o_data;

    modport slave (
        input  req_valid, req_op, req_key, req_mode, req_data, req_tag, rsp_ready,
               key_o_key_ready, cph_o_ready, cph_o_data_valid, cph_o_data,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
               key_i_key, key_i_key_mode, key_i_start,
               cph_i_data, cph_i_data_valid, cph_i_ende, cph_i_enable
    );

    modport master (
        output req_valid, req_op, req_key, req_mode, req_data, req_tag, rsp_ready,
               key_o_key_ready, cph_o_ready, cph_o_data_valid, cph_o_data,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
               key_i_key, key_i_key_mode, key_i_start,
               cph_i_data, cph_i_data_valid, cph_i_ende, cph_i_enable
    );
endinterface

// File: rtl/aes_txn_sequencer.sv
// rtl/aes_txn_sequencer.sv - queues AES key-load/encrypt/decrypt requests and sequences the cores
module aes_txn_sequencer #(
    parameter int DATA_W  = 128,
    parameter int KEY_W   = 256,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset_n,
    aes_txn_sequencer_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int RQ_W  = 2 + KEY_W + 2 + DATA_W + TAG_W;
    localparam int RS_W  = DATA_W + TAG_W + 2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_NOKEY   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_KEY_START, S_KEY_WAIT, S_CPH_WAIT_RDY, S_CPH_ISSUE, S_CPH_WAIT_DATA, S_RESP
    } state_e;

    // request FIFO
    logic [RQ_W-1:0] rq_mem [DEPTH];
    logic [AW:0]     rq_wptr_q, rq_rptr_q;
    logic            rq_empty, rq_full, rq_push, rq_pop;
    logic [1:0]        hd_op, hd_mode;
    logic [KEY_W-1:0]  hd_key;
    logic [DATA_W-1:0] hd_data;
    logic [TAG_W-1:0]  hd_tag;

    assign rq_empty      = (rq_wptr_q == rq_rptr_q);
    assign rq_full       = (rq_wptr_q[AW] != rq_rptr_q[AW]) && (rq_wptr_q[AW-1:0] == rq_rptr_q[AW-1:0]);
    assign bus.req_ready = reset_n && !rq_full;
    assign rq_push       = bus.req_valid && bus.req_ready;
    assign {hd_op, hd_key, hd_mode, hd_data, hd_tag} = rq_mem[rq_rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rq_push) begin
            rq_mem[rq_wptr_q[AW-1:0]] <= {bus.req_op, bus.req_key, bus.req_mode, bus.req_data, bus.req_tag};
        end
    end

    // response FIFO
    logic [RS_W-1:0]   rs_mem [DEPTH];
    logic [AW:0]       rs_wptr_q, rs_rptr_q;
    logic              rs_empty, rs_full, rs_push, rs_pop;
    logic [DATA_W-1:0] rs_data;
    logic [TAG_W-1:0]  rs_tag;
    logic [1:0]        rs_err;

    assign rs_empty = (rs_wptr_q == rs_rptr_q);
    assign rs_full  = (rs_wptr_q[AW] != rs_rptr_q[AW]) && (rs_wptr_q[AW-1:0] == rs_rptr_q[AW-1:0]);
    assign rs_pop   = bus.rsp_valid && bus.rsp_ready;
    assign {rs_data, rs_tag, rs_err} = rs_mem[rs_rptr_q[AW-1:0]];

    // payload is gated so nothing stale or uninitialised is visible without rsp_valid
    assign bus.rsp_valid = !rs_empty;
    assign bus.rsp_data  = bus.rsp_valid ? rs_data : '0;
    assign bus.rsp_tag   = bus.rsp_valid ? rs_tag  : '0;
    assign bus.rsp_err   = bus.rsp_valid ? rs_err  : '0;

    // FSM and transaction state
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              key_loaded_q, key_loaded_d;
    logic [1:0]        cur_op_q, cur_op_d, cur_mode_q, cur_mode_d;
    logic [KEY_W-1:0]  cur_key_q, cur_key_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d, res_data_q, res_data_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [1:0]        res_err_q, res_err_d;
    logic              timed_out;

    always_ff @(posedge clk) begin
        if (rs_push) begin
            rs_mem[rs_wptr_q[AW-1:0]] <= {res_data_q, cur_tag_q, res_err_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rq_wptr_q    <= '0;
            rq_rptr_q    <= '0;
            rs_wptr_q    <= '0;
            rs_rptr_q    <= '0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            cur_op_q     <= '0;
            cur_mode_q   <= '0;
            cur_key_q    <= '0;
            cur_data_q   <= '0;
            cur_tag_q    <= '0;
            res_data_q   <= '0;
            res_err_q    <= '0;
        end else begin
            if (rq_push) rq_wptr_q <= rq_wptr_q + 1'b1;
            if (rq_pop)  rq_rptr_q <= rq_rptr_q + 1'b1;
            if (rs_push) rs_wptr_q <= rs_wptr_q + 1'b1;
            if (rs_pop)  rs_rptr_q <= rs_rptr_q + 1'b1;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            cur_op_q     <= cur_op_d;
            cur_mode_q   <= cur_mode_d;
            cur_key_q    <= cur_key_d;
            cur_data_q   <= cur_data_d;
            cur_tag_q    <= cur_tag_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
        end
    end

    // counter value k means the current cycle is the (k+1)-th spent in a wait state
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        key_loaded_d = key_loaded_q;
        cur_op_d     = cur_op_q;
        cur_mode_d   = cur_mode_q;
        cur_key_d    = cur_key_q;
        cur_data_d   = cur_data_q;
        cur_tag_d    = cur_tag_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        rq_pop       = 1'b0;
        rs_push      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rq_empty && !rs_full) begin
                    rq_pop     = 1'b1;
                    cur_op_d   = hd_op;
                    cur_mode_d = hd_mode;
                    cur_key_d  = hd_key;
                    cur_data_d = hd_data;
                    cur_tag_d  = hd_tag;
                    res_data_d = '0;
                    res_err_d  = ERR_OK;
                    case (hd_op)
                        2'b00: begin
                            state_d      = S_KEY_START;
                            key_loaded_d = 1'b0;
                        end
                        2'b11: begin
                            state_d   = S_RESP;
                            res_err_d = ERR_ILLEGAL;
                        end
                        default: begin
                            if (key_loaded_q) begin
                                state_d = S_CPH_WAIT_RDY;
                            end else begin
                                state_d   = S_RESP;
                                res_err_d = ERR_NOKEY;
                            end
                        end
                    endcase
                end
            end
            S_KEY_START: state_d = S_KEY_WAIT;
            S_KEY_WAIT: begin
                if (bus.key_o_key_ready) begin
                    state_d      = S_RESP;
                    key_loaded_d = 1'b1;
                end else if (timed_out) begin
                    state_d      = S_RESP;
                    res_err_d    = ERR_TIMEOUT;
                    key_loaded_d = 1'b0;
                end
            end
            S_CPH_WAIT_RDY: begin
                if (bus.cph_o_ready) begin
                    state_d = S_CPH_ISSUE;
                end else if (timed_out) begin
                    state_d   = S_RESP;
                    res_err_d = ERR_TIMEOUT;
                end
            end
            S_CPH_ISSUE: state_d = S_CPH_WAIT_DATA;
            S_CPH_WAIT_DATA: begin
                if (bus.cph_o_data_valid) begin
                    state_d    = S_RESP;
                    res_data_d = bus.cph_o_data;
                end else if (timed_out) begin
                    state_d   = S_RESP;
                    res_err_d = ERR_TIMEOUT;
                end
            end
            S_RESP: begin
                rs_push = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if ((state_d == state_q) &&
            (state_q == S_KEY_WAIT || state_q == S_CPH_WAIT_RDY || state_q == S_CPH_WAIT_DATA)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // key stays presented through expansion so the core may sample it late
    assign bus.key_i_start      = (state_q == S_KEY_START);
    assign bus.key_i_key        = (state_q == S_KEY_START || state_q == S_KEY_WAIT) ? cur_key_q  : '0;
    assign bus.key_i_key_mode   = (state_q == S_KEY_START || state_q == S_KEY_WAIT) ? cur_mode_q : '0;
    assign bus.cph_i_data_valid = (state_q == S_CPH_ISSUE);
    assign bus.cph_i_data       = (state_q == S_CPH_ISSUE) ? cur_data_q : '0;
    assign bus.cph_i_enable     = (state_q == S_CPH_ISSUE || state_q == S_CPH_WAIT_DATA);
    assign bus.cph_i_ende       = bus.cph_i_enable && cur_op_q[1];
endmodule
